// File: rtl/rdma_rx_pkg.sv
// Shared widths, FIFO entry layout and drain FSM states for the RDMA receive sink.
package rdma_rx_pkg;

    localparam int DATA_W  = 256;
    localparam int QN_W    = 4;
    localparam int LINES_W = 6;

    // One buffered payload line together with the queue it belongs to.
    typedef struct packed {
        logic [QN_W-1:0]   qn;
        logic [DATA_W-1:0] data;
    } entry_t;

    // IDLE: nothing presented to memory; WRITE: a line is held on the write master.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } drain_state_e;

endpackage

// File: rtl/rdma_sync_fifo.sv
// Parameterized synchronous FIFO with registered occupancy count and full/empty flags.
// Read data is show-ahead: rdData_o always presents the current head entry.
module rdma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wrEn_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    output logic [WIDTH-1:0] rdData_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doWrite;
    logic             doRead;

    // Writes into a full FIFO and reads from an empty one are ignored here as well,
    // so the storage can never be corrupted whatever the caller does.
    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign doWrite  = wrEn_i && !full_o;
    assign doRead   = rdEn_i && !empty_o;
    assign rdData_o = mem_q[rdPtr_q];
    assign count_o  = count_q;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doRead) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doWrite, doRead})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/rdma_push_sink.sv
// Receive-path sink: buffers tagged payload lines and writes each one to its queue's
// ring in host memory, keeping one ring write pointer per queue.
// Payload, queue-number and ring widths come from rdma_rx_pkg.
module rdma_push_sink
    import rdma_rx_pkg::*;
#(
    parameter int                DEPTH     = 8,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  pushData,
    input  logic [QN_W-1:0]    QN,
    output logic               ready,
    output logic [ADDR_W-1:0]  memAddress,
    output logic [DATA_W-1:0]  memWriteData,
    output logic               memWrite,
    input  logic               memWaitRequest,
    input  logic               qClear,
    input  logic [QN_W-1:0]    qClearNum,
    input  logic [QN_W-1:0]    ptrRdAddr,
    output logic [LINES_W-1:0] ptrRdData,
    output logic               overflowErr
);

    localparam int                NUM_Q      = 1 << QN_W;
    localparam int                FIFO_CW    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(DATA_W / 8);

    drain_state_e       state_q;
    drain_state_e       state_d;
    entry_t             pushEntry;
    entry_t             headEntry;
    logic [FIFO_CW-1:0] fifoCount;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               load;
    logic               writeDone;
    logic [LINES_W-1:0] headPtr;
    logic [ADDR_W-1:0]  lineIndex;
    logic [ADDR_W-1:0]  loadAddr;
    logic [LINES_W-1:0] wrPtr_q [NUM_Q];
    logic [LINES_W-1:0] wrPtr_d [NUM_Q];
    logic [QN_W-1:0]    inflightQn_q;
    logic [ADDR_W-1:0]  memAddress_q;
    logic [DATA_W-1:0]  memWriteData_q;
    logic               overflow_q;

    assign pushEntry = '{qn: QN, data: pushData};

    rdma_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wrEn_i   (push),
        .wrData_i (pushEntry),
        .rdEn_i   (load),
        .rdData_o (headEntry),
        .count_o  (fifoCount),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // ready depends only on the registered count, so a full FIFO refuses a push even
    // when the drain pops in the same cycle.
    assign ready        = (fifoCount != FIFO_CW'(DEPTH));
    assign writeDone    = (state_q == ST_WRITE) && !memWaitRequest;
    assign memWrite     = (state_q == ST_WRITE);
    assign memAddress   = memAddress_q;
    assign memWriteData = memWriteData_q;
    assign ptrRdData    = wrPtr_q[ptrRdAddr];
    assign overflowErr  = overflow_q;

    // Drain FSM next state: pop whenever idle or finishing a write and a line is waiting.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    load    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!memWaitRequest) begin
                    if (!fifoEmpty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Ring address of the head line; a completing write to the same queue forwards its
    // incremented pointer so back-to-back lines land in consecutive slots.
    always_comb begin
        headPtr = wrPtr_q[headEntry.qn];
        if (writeDone && (inflightQn_q == headEntry.qn)) begin
            headPtr = wrPtr_q[inflightQn_q] + 1'b1;
        end
    end

    assign lineIndex = ADDR_W'({headEntry.qn, headPtr});
    assign loadAddr  = BASE_ADDR + lineIndex * LINE_BYTES;

    // Per-queue pointer update: a clear beats a completing write to the same queue.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            wrPtr_d[i] = wrPtr_q[i];
            if (qClear && (qClearNum == QN_W'(i))) begin
                wrPtr_d[i] = '0;
            end else if (writeDone && (inflightQn_q == QN_W'(i))) begin
                wrPtr_d[i] = wrPtr_q[i] + 1'b1;
            end
        end
    end

    // FSM state and ring pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NUM_Q; i++) begin
                wrPtr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NUM_Q; i++) begin
                wrPtr_q[i] <= wrPtr_d[i];
            end
        end
    end

    // Write-master holding registers, loaded on each pop, plus the sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            memAddress_q   <= '0;
            memWriteData_q <= '0;
            inflightQn_q   <= '0;
            overflow_q     <= 1'b0;
        end else begin
            if (load) begin
                memAddress_q   <= loadAddr;
                memWriteData_q <= headEntry.data;
                inflightQn_q   <= headEntry.qn;
            end
            if (push && fifoFull) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rdma_push_sink.sv
// Self-checking bench for rdma_push_sink: directed scenarios plus a randomized run,
// all checked against a queue-based model of ring addresses per queue.
module tb_rdma_push_sink;
    import rdma_rx_pkg::*;

    localparam int          NUM_Q      = 16;
    localparam int          RING_LINES = 64;
    localparam int          LINE_BYTES = 32;
    localparam logic [31:0] BASE       = 32'h0;

    logic         clock = 1'b0;
    logic         reset;
    logic         push;
    logic [255:0] pushData;
    logic [3:0]   QN;
    logic         ready;
    logic [31:0]  memAddress;
    logic [255:0] memWriteData;
    logic         memWrite;
    logic         memWaitRequest;
    logic         qClear;
    logic [3:0]   qClearNum;
    logic [3:0]   ptrRdAddr;
    logic [5:0]   ptrRdData;
    logic         overflowErr;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
        int           cyc;
    } wr_t;

    wr_t expQ[$];
    wr_t obsQ[$];
    int  modelPtr [NUM_Q];
    int  cycleCnt    = 0;
    int  nCompared   = 0;
    int  nMismatched = 0;

    rdma_push_sink #(
        .DEPTH     (8),
        .ADDR_W    (32),
        .BASE_ADDR (BASE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .push           (push),
        .pushData       (pushData),
        .QN             (QN),
        .ready          (ready),
        .memAddress     (memAddress),
        .memWriteData   (memWriteData),
        .memWrite       (memWrite),
        .memWaitRequest (memWaitRequest),
        .qClear         (qClear),
        .qClearNum      (qClearNum),
        .ptrRdAddr      (ptrRdAddr),
        .ptrRdData      (ptrRdData),
        .overflowErr    (overflowErr)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    // Record every write that completes at the coming edge.
    always @(negedge clock) begin
        if (reset === 1'b0 && memWrite === 1'b1 && memWaitRequest === 1'b0) begin
            obsQ.push_back('{addr: memAddress, data: memWriteData, cyc: cycleCnt});
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] expAddr(input int q, input int idx);
        int unsigned lineNo;
        lineNo = q * RING_LINES + idx;
        return BASE + 32'(lineNo * LINE_BYTES);
    endfunction

    function automatic logic [255:0] randLine();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model: each accepted line lands in the next slot of its queue's ring.
    task automatic expectLine(input int q, input logic [255:0] d);
        expQ.push_back('{addr: expAddr(q, modelPtr[q]), data: d, cyc: 0});
        modelPtr[q] = (modelPtr[q] + 1) % RING_LINES;
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_Q; i++) modelPtr[i] = 0;
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic pushLine(input logic [3:0] q, input logic [255:0] d);
        push = 1'b1;
        QN = q;
        pushData = d;
        @(posedge clock);
        #1;
        push = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        push = 1'b0;
        qClear = 1'b0;
        memWaitRequest = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clearModel();
    endtask

    task automatic waitWrites(input int n, input string name);
        for (int c = 0; c < 300 && obsQ.size() < n; c++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
        nCompared++;
        if (obsQ.size() != n) begin
            nMismatched++;
            $display("[TB] FAIL %s_count: got %0d writes, expected %0d", name, obsQ.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push = 1'b0;
        qClear = 1'b0;
        qClearNum = '0;
        memWaitRequest = 1'b0;
        QN = '0;
        pushData = '0;
        ptrRdAddr = '0;
        #2;
        nCompared++;
        if ({memWrite, overflowErr} !== 2'b00 || memAddress !== 32'h0 || memWriteData !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got wr=%b ovf=%b addr=%h, expected all zero",
                     memWrite, overflowErr, memAddress);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clearModel();
        nCompared++;
        if (ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
        for (int i = 0; i < NUM_Q; i++) begin
            ptrRdAddr = 4'(i);
            #1;
            nCompared++;
            if (ptrRdData !== 6'd0) begin
                nMismatched++;
                $display("[TB] FAIL reset_ptr%0d: got %0d expected 0", i, ptrRdData);
            end
        end
    endtask

    task automatic test_single();
        logic [255:0] d;
        d = {8{32'hA5A5A5A5}};
        @(posedge clock);
        #1;
        obsQ.delete();
        expectLine(3, d);
        pushLine(4'd3, d);
        @(negedge clock);
        nCompared++;
        if (memWrite !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_early: memWrite got %b expected 0", memWrite);
        end
        @(negedge clock);
        nCompared++;
        if (memWrite !== 1'b1 || memAddress !== 32'h1800 || memWriteData !== d) begin
            nMismatched++;
            $display("[TB] FAIL single_write: got wr=%b addr=%h expected wr=1 addr=00001800",
                     memWrite, memAddress);
        end
        @(negedge clock);
        nCompared++;
        if (memWrite !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_len: memWrite got %b expected 0", memWrite);
        end
        ptrRdAddr = 4'd3;
        #1;
        nCompared++;
        if (ptrRdData !== 6'(modelPtr[3])) begin
            nMismatched++;
            $display("[TB] FAIL single_ptr: got %0d expected %0d", ptrRdData, modelPtr[3]);
        end
        waitWrites(1, "single");
        expQ.delete();
        obsQ.delete();
    endtask

    // With the drain stalled, one line sits in the write register and eight in the FIFO.
    task automatic test_overflow();
        logic [255:0] d;
        int q;
        applyReset();
        memWaitRequest = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = randLine();
            q = $urandom_range(0, 15);
            if (i < 9) expectLine(q, d);
            push = 1'b1;
            QN = 4'(q);
            pushData = d;
            @(posedge clock);
            #1;
            nCompared++;
            if (ready !== (i < 8) || overflowErr !== (i == 9)) begin
                nMismatched++;
                $display("[TB] FAIL overflow_flags%0d: got ready=%b ovf=%b expected ready=%b ovf=%b",
                         i, ready, overflowErr, (i < 8), (i == 9));
            end
        end
        push = 1'b0;
        repeat (3) begin
            @(negedge clock);
            nCompared++;
            if (memWrite !== 1'b1 || memAddress !== expQ[0].addr) begin
                nMismatched++;
                $display("[TB] FAIL overflow_hold: got wr=%b addr=%h expected wr=1 addr=%h",
                         memWrite, memAddress, expQ[0].addr);
            end
        end
        @(posedge clock);
        #1;
        memWaitRequest = 1'b0;
        waitWrites(9, "overflow");
        for (int i = 0; i < 9 && i < obsQ.size(); i++) begin
            nCompared++;
            if (obsQ[i].addr !== expQ[i].addr || obsQ[i].data !== expQ[i].data) begin
                nMismatched++;
                $display("[TB] FAIL overflow_order%0d: got addr=%h expected addr=%h",
                         i, obsQ[i].addr, expQ[i].addr);
            end
        end
        nCompared++;
        if (overflowErr !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", overflowErr);
        end
    endtask

    task automatic test_wrap();
        logic [255:0] d;
        applyReset();
        for (int i = 0; i < 65; i++) begin
            d = randLine();
            expectLine(0, d);
            push = 1'b1;
            QN = 4'd0;
            pushData = d;
            @(posedge clock);
            #1;
        end
        push = 1'b0;
        waitWrites(65, "wrap");
        for (int i = 0; i < 65 && i < obsQ.size(); i++) begin
            nCompared++;
            if (obsQ[i].addr !== expQ[i].addr || obsQ[i].data !== expQ[i].data ||
                obsQ[i].cyc !== obsQ[0].cyc + i) begin
                nMismatched++;
                $display("[TB] FAIL wrap_write%0d: got addr=%h cyc=%0d expected addr=%h cyc=%0d",
                         i, obsQ[i].addr, obsQ[i].cyc, expQ[i].addr, obsQ[0].cyc + i);
            end
        end
        ptrRdAddr = 4'd0;
        #1;
        nCompared++;
        if (ptrRdData !== 6'd1) begin
            nMismatched++;
            $display("[TB] FAIL wrap_ptr: got %0d expected 1", ptrRdData);
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_back_to_back_stall();
        logic [255:0] dA;
        logic [255:0] dB;
        int q;
        q = $urandom_range(0, 15);
        dA = randLine();
        dB = randLine();
        @(posedge clock);
        #1;
        obsQ.delete();
        memWaitRequest = 1'b1;
        expectLine(q, dA);
        expectLine(q, dB);
        pushLine(4'(q), dA);
        pushLine(4'(q), dB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            nCompared++;
            if (memWrite !== 1'b1 || memAddress !== expQ[0].addr || memWriteData !== dA) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold%0d: got wr=%b addr=%h expected wr=1 addr=%h",
                         i, memWrite, memAddress, expQ[0].addr);
            end
        end
        @(posedge clock);
        #1;
        memWaitRequest = 1'b0;
        waitWrites(2, "stall");
        for (int i = 0; i < 2 && i < obsQ.size(); i++) begin
            nCompared++;
            if (obsQ[i].addr !== expQ[i].addr || obsQ[i].data !== expQ[i].data ||
                obsQ[i].cyc !== obsQ[0].cyc + i) begin
                nMismatched++;
                $display("[TB] FAIL stall_write%0d: got addr=%h cyc=%0d expected addr=%h cyc=%0d",
                         i, obsQ[i].addr, obsQ[i].cyc, expQ[i].addr, obsQ[0].cyc + i);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_clear();
        logic [255:0] d;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            d = randLine();
            expectLine(2, d);
            pushLine(4'd2, d);
        end
        waitWrites(3, "clear_pre");
        expQ.delete();
        obsQ.delete();
        memWaitRequest = 1'b1;
        d = randLine();
        expectLine(2, d);
        pushLine(4'd2, d);
        @(posedge clock);
        #1;
        memWaitRequest = 1'b0;
        qClear = 1'b1;
        qClearNum = 4'd2;
        @(posedge clock);
        #1;
        qClear = 1'b0;
        modelPtr[2] = 0;
        ptrRdAddr = 4'd2;
        #1;
        nCompared++;
        if (ptrRdData !== 6'd0) begin
            nMismatched++;
            $display("[TB] FAIL clear_ptr: got %0d expected 0", ptrRdData);
        end
        d = randLine();
        expectLine(2, d);
        pushLine(4'd2, d);
        waitWrites(2, "clear");
        for (int i = 0; i < 2 && i < obsQ.size(); i++) begin
            nCompared++;
            if (obsQ[i].addr !== expQ[i].addr || obsQ[i].data !== expQ[i].data) begin
                nMismatched++;
                $display("[TB] FAIL clear_write%0d: got addr=%h expected addr=%h",
                         i, obsQ[i].addr, expQ[i].addr);
            end
        end
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_reset_mid_write();
        memWaitRequest = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) pushLine(4'(5 + i), randLine());
        @(negedge clock);
        nCompared++;
        if (memWrite !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL midreset_pre: memWrite got %b expected 1", memWrite);
        end
        reset = 1'b1;
        #1;
        nCompared++;
        if (memWrite !== 1'b0 || memAddress !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_drop: got wr=%b addr=%h expected wr=0 addr=0",
                     memWrite, memAddress);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        memWaitRequest = 1'b0;
        clearModel();
        nCompared++;
        if (ready !== 1'b1 || overflowErr !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_ready: got ready=%b ovf=%b expected ready=1 ovf=0",
                     ready, overflowErr);
        end
        for (int i = 0; i < NUM_Q; i++) begin
            ptrRdAddr = 4'(i);
            #1;
            nCompared++;
            if (ptrRdData !== 6'd0) begin
                nMismatched++;
                $display("[TB] FAIL midreset_ptr%0d: got %0d expected 0", i, ptrRdData);
            end
        end
        repeat (10) @(posedge clock);
        #1;
        nCompared++;
        if (obsQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_lost: got %0d writes expected 0", obsQ.size());
        end
    endtask

    task automatic test_random();
        logic [255:0] d;
        int q;
        applyReset();
        for (int c = 0; c < 400; c++) begin
            memWaitRequest = ($urandom_range(0, 9) < 3);
            if (ready === 1'b1 && $urandom_range(0, 9) < 6) begin
                q = $urandom_range(0, 3);
                d = randLine();
                expectLine(q, d);
                push = 1'b1;
                QN = 4'(q);
                pushData = d;
            end else begin
                push = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        push = 1'b0;
        memWaitRequest = 1'b0;
        waitWrites(expQ.size(), "random");
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            nCompared++;
            if (obsQ[i].addr !== expQ[i].addr || obsQ[i].data !== expQ[i].data) begin
                nMismatched++;
                $display("[TB] FAIL random_write%0d: got addr=%h expected addr=%h",
                         i, obsQ[i].addr, expQ[i].addr);
            end
        end
        for (int i = 0; i < 4; i++) begin
            ptrRdAddr = 4'(i);
            #1;
            nCompared++;
            if (ptrRdData !== 6'(modelPtr[i])) begin
                nMismatched++;
                $display("[TB] FAIL random_ptr%0d: got %0d expected %0d", i, ptrRdData, modelPtr[i]);
            end
        end
        nCompared++;
        if (overflowErr !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL random_ovf: got %b expected 0", overflowErr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_back_to_back_stall();
        test_clear();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
